// File: rtl/unary_bin_decoder_pkg.sv
// Shared sizing for the stochastic encode/decode chain.
// The window-counter width is defined here so the encoder and decoder stay matched.
package unary_bin_decoder_pkg;

  localparam int unsigned DEF_BITWIDTH = 8;
  localparam int unsigned WINDOW       = 1 << DEF_BITWIDTH;

endpackage : unary_bin_decoder_pkg

// File: rtl/unary_bin_decoder_cntwithen.sv
// Enabled, clearable up-counter that wraps naturally at all-ones.
// Used as the window phase counter.
module unary_bin_decoder_cntwithen
  import unary_bin_decoder_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_BITWIDTH
) (
  input  logic             iClk,
  input  logic             iRstN,
  input  logic             iEn,
  input  logic             iClr,
  output logic [WIDTH-1:0] oCnt
);

  // Clear has priority over enable.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      oCnt <= '0;
    end else if (iClr) begin
      oCnt <= '0;
    end else if (iEn) begin
      oCnt <= oCnt + WIDTH'(1);
    end
  end

endmodule : unary_bin_decoder_cntwithen

// File: rtl/unary_bin_decoder.sv
// Recovers a binary value from a unipolar stochastic bitstream by counting
// ones over a window of 2^BITWIDTH enabled samples.
module unary_bin_decoder
  import unary_bin_decoder_pkg::*;
#(
  parameter int unsigned BITWIDTH = DEF_BITWIDTH
) (
  input  logic                iClk,
  input  logic                iRstN,
  input  logic                iEn,
  input  logic                iClr,
  input  logic                iBit,
  output logic [BITWIDTH:0]   oValue,
  output logic                oValid,
  output logic [BITWIDTH-1:0] oPhase
);

  localparam int unsigned VW = BITWIDTH + 1;

  logic [BITWIDTH-1:0] acc;
  logic                window_done_c;

  unary_bin_decoder_cntwithen #(
    .WIDTH (BITWIDTH)
  ) u_phase (
    .iClk  (iClk),
    .iRstN (iRstN),
    .iEn   (iEn),
    .iClr  (iClr),
    .oCnt  (oPhase)
  );

  assign window_done_c = iEn & ~iClr & (&oPhase);

  // acc holds at most 2^BITWIDTH-1 ones; the final sample is added at full width.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      acc    <= '0;
      oValue <= '0;
      oValid <= 1'b0;
    end else if (iClr) begin
      acc    <= '0;
      oValid <= 1'b0;
    end else if (window_done_c) begin
      oValue <= VW'(acc) + VW'(iBit);
      acc    <= '0;
      oValid <= 1'b1;
    end else if (iEn) begin
      acc    <= acc + BITWIDTH'(iBit);
      oValid <= 1'b0;
    end else begin
      oValid <= 1'b0;
    end
  end

endmodule : unary_bin_decoder

// File: tb/tb_unary_bin_decoder.sv
// Self-checking bench: directed windows plus random stimulus against an
// integer-counting reference model, compared every cycle.
module tb_unary_bin_decoder;

  localparam int unsigned BW  = 4;
  localparam int          WIN = 1 << BW;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic          clr;
  logic          sbit;
  logic [BW:0]   value;
  logic          valid;
  logic [BW-1:0] phase;

  int vectors;
  int miscompares;

  unary_bin_decoder #(.BITWIDTH(BW)) dut (
    .iClk   (clk),
    .iRstN  (rst_n),
    .iEn    (en),
    .iClr   (clr),
    .iBit   (sbit),
    .oValue (value),
    .oValid (valid),
    .oPhase (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: count enabled samples and ones as plain integers.
  int   m_n;
  int   m_ones;
  int   m_value;
  logic m_valid;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_n = 0; m_ones = 0; m_value = 0; m_valid = 1'b0;
    end else if (clr) begin
      m_n = 0; m_ones = 0; m_valid = 1'b0;
    end else if (en) begin
      m_ones = m_ones + int'(sbit);
      m_n    = m_n + 1;
      m_valid = 1'b0;
      if (m_n == WIN) begin
        m_value = m_ones;
        m_valid = 1'b1;
        m_n     = 0;
        m_ones  = 0;
      end
    end else begin
      m_valid = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      vectors++;
      if (value !== (BW+1)'(m_value) || valid !== m_valid || phase !== BW'(m_n)) begin
        miscompares++;
        $display("FAIL model t=%0t value=%0d/%0d valid=%0b/%0b phase=%0d/%0d (got/want)",
                 $time, value, m_value, valid, m_valid, phase, m_n);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic step(input logic e, input logic c, input logic b);
    en = e; clr = c; sbit = b;
    @(posedge clk);
    #1;
  endtask

  // kind: 0 all ones, 1 all zeros, 2 alternating 1,0, 3 repeating 1,1,1,0
  function automatic logic pat(input int kind, input int i);
    case (kind)
      0:       return 1'b1;
      1:       return 1'b0;
      2:       return (i % 2 == 0);
      default: return (i % 4 != 3);
    endcase
  endfunction

  task automatic window(input int kind, input int want, input string name);
    for (int i = 0; i < WIN; i++) begin
      step(1'b1, 1'b0, pat(kind, i));
      if (i == WIN - 2) chk({name, "_novalid_early"}, int'(valid), 0);
    end
    chk({name, "_valid"}, int'(valid), 1);
    chk({name, "_value"}, int'(value), want);
    chk({name, "_phase"}, int'(phase), 0);
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; sbit = 1'b0;
    #12;
    chk("reset_value", int'(value), 0);
    chk("reset_valid", int'(valid), 0);
    chk("reset_phase", int'(phase), 0);
    #4 rst_n = 1'b1;

    window(0, 16, "ones");
    step(1'b0, 1'b0, 1'b0);
    chk("valid_one_cycle", int'(valid), 0);
    chk("value_holds", int'(value), 16);
    window(1, 0, "zeros");
    window(0, 16, "ones_b2b");
    window(2, 8, "alt");
    window(3, 12, "p1110");

    // Alternating stream stretched by 5 disabled cycles carrying iBit=1.
    begin
      int k;
      k = 0;
      for (int c = 0; c < WIN + 5; c++) begin
        if (c == 2 || c == 5 || c == 9 || c == 13 || c == 17) begin
          step(1'b0, 1'b0, 1'b1);
        end else begin
          step(1'b1, 1'b0, pat(2, k));
          k++;
        end
        if (c == WIN + 3) chk("gap_novalid_early", int'(valid), 0);
      end
      chk("gap_valid", int'(valid), 1);
      chk("gap_value", int'(value), 8);
    end

    // Clear mid-window abandons the partial count but keeps the last result.
    window(3, 12, "pre_clr");
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b1);
    chk("pre_clr_phase", int'(phase), 7);
    step(1'b1, 1'b1, 1'b1);
    chk("clr_phase", int'(phase), 0);
    chk("clr_value", int'(value), 12);
    chk("clr_valid", int'(valid), 0);
    window(0, 16, "post_clr");

    // Asynchronous reset mid-window, applied between clock edges.
    window(3, 12, "pre_rst");
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0);
    chk("pre_rst_phase", int'(phase), 9);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_value", int'(value), 0);
    chk("arst_valid", int'(valid), 0);
    chk("arst_phase", int'(phase), 0);
    en = 1'b0;
    #10 rst_n = 1'b1;
    window(0, 16, "post_rst");

    // Random traffic checked cycle by cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 63) == 0), 1'($urandom));
    end
    step(1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_unary_bin_decoder
